// File: rtl/i2c_bus_sniffer.sv
// Passive I2C observer: synchronises and glitch-filters SCL/SDA, detects START/STOP,
// deserialises 9-bit frames into {first, ack, data} records and queues them in a small FIFO.
module i2c_bus_sniffer #(
  parameter int FILTER_LEN = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic       en_i,
  input  logic       rec_ready_i,
  output logic       rec_valid_o,
  output logic [7:0] rec_data_o,
  output logic       rec_ack_o,
  output logic       rec_first_o,
  output logic       bus_busy_o,
  output logic       start_pulse_o,
  output logic       stop_pulse_o,
  output logic       frame_err_o,
  output logic       overflow_o
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic       first;
    logic       ack;
    logic [7:0] data;
  } rec_t;

  typedef enum logic {IDLE, BUSY} state_t;

  // Line front end, bit 1 = SCL, bit 0 = SDA.
  logic [1:0] raw, sync1, sync2, filt, filt_d;
  logic [3:0] fcnt [2];

  assign raw = {scl_i, sda_i};

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update together on the edge and the synchroniser stages do not collapse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_d <= '1;
      fcnt   <= '{default: '0};
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  // SDA edges count as START/STOP only while SCL has been high on both sides of the edge.
  logic start_ev, stop_ev, scl_rise;
  assign start_ev = filt[1] & filt_d[1] &  filt_d[0] & ~filt[0];
  assign stop_ev  = filt[1] & filt_d[1] & ~filt_d[0] &  filt[0];
  assign scl_rise = filt[1] & ~filt_d[1];

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       first_pending;
  logic       push;
  rec_t       push_rec;

  assign push       = en_i & (state == BUSY) & scl_rise & (bit_cnt == 4'd8) & ~start_ev & ~stop_ev;
  assign push_rec   = '{first: first_pending, ack: filt[0], data: shreg};
  assign bus_busy_o = (state == BUSY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      first_pending <= 1'b0;
      start_pulse_o <= 1'b0;
      stop_pulse_o  <= 1'b0;
      frame_err_o   <= 1'b0;
    end else if (!en_i) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      first_pending <= 1'b0;
      start_pulse_o <= 1'b0;
      stop_pulse_o  <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      start_pulse_o <= 1'b0;
      stop_pulse_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      if (start_ev) begin
        // A single pending sample is the SCL rise that precedes a repeated START.
        frame_err_o   <= (state == BUSY) && (bit_cnt >= 4'd2);
        state         <= BUSY;
        start_pulse_o <= 1'b1;
        first_pending <= 1'b1;
        bit_cnt       <= '0;
      end else if (stop_ev) begin
        if (state == BUSY) begin
          frame_err_o  <= (bit_cnt >= 4'd2);
          state        <= IDLE;
          stop_pulse_o <= 1'b1;
          bit_cnt      <= '0;
        end
      end else if (scl_rise && state == BUSY) begin
        if (bit_cnt == 4'd8) begin
          bit_cnt       <= '0;
          first_pending <= 1'b0;
        end else begin
          shreg   <= {shreg[6:0], filt[0]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  // Record FIFO.
  rec_t           mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           full, pop, do_push;
  rec_t           head;

  assign full    = (count == DEPTH_CNT);
  assign pop     = rec_valid_o & rec_ready_i;
  assign do_push = push & (~full | pop);

  // NOTE: the storage array has no reset; the head outputs are masked whenever
  // the FIFO is empty, so stale entries are never visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_rec;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(pop);
      if (!en_i)                     overflow_o <= 1'b0;
      else if (push && full && !pop) overflow_o <= 1'b1;
    end
  end

  assign rec_valid_o = (count != '0);
  assign head        = rec_valid_o ? mem[rd_ptr] : '0;
  assign rec_data_o  = head.data;
  assign rec_ack_o   = head.ack;
  assign rec_first_o = head.first;

endmodule

// File: tb/tb_i2c_bus_sniffer.sv
// Self-checking bench for i2c_bus_sniffer: table-driven byte vectors, directed corner
// sequences and a randomized transaction phase scored against a transaction-level model.
`timescale 1ns/1ps
module tb_i2c_bus_sniffer;

  localparam int FL    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, scl, sda, en, rec_ready;
  logic       rec_valid, rec_ack, rec_first, bus_busy;
  logic       start_pulse, stop_pulse, frame_err, overflow;
  logic [7:0] rec_data;

  always #5 clk = ~clk;

  i2c_bus_sniffer #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda), .en_i(en),
    .rec_ready_i(rec_ready), .rec_valid_o(rec_valid), .rec_data_o(rec_data),
    .rec_ack_o(rec_ack), .rec_first_o(rec_first), .bus_busy_o(bus_busy),
    .start_pulse_o(start_pulse), .stop_pulse_o(stop_pulse),
    .frame_err_o(frame_err), .overflow_o(overflow)
  );

  typedef struct packed {
    logic       first;
    logic       ack;
    logic [7:0] data;
  } rec_t;

  typedef struct {
    logic       restart;
    logic [7:0] data;
    logic       ack;
    logic [9:0] exp_rec;
  } vec_t;

  int   n_tests = 0, n_fail = 0;
  int   n_start = 0, n_stop = 0, n_ferr = 0;
  int   e_start = 0, e_stop = 0, e_ferr = 0;
  rec_t exp_q[$];
  bit   m_busy = 0, m_first = 0, m_ovf = 0;
  int   m_bits = 0;
  int   half = 8;
  bit   done;

  always @(negedge clk) begin
    if (start_pulse === 1'b1) n_start++;
    if (stop_pulse  === 1'b1) n_stop++;
    if (frame_err   === 1'b1) n_ferr++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] head_rec();
    return 32'({rec_first, rec_ack, rec_data});
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_starts"}, n_start, e_start);
    check({tag, "_stops"},  n_stop,  e_stop);
    check({tag, "_ferrs"},  n_ferr,  e_ferr);
  endtask

  task automatic model_push(input logic [7:0] data, input logic ack);
    if (m_busy) begin
      if (exp_q.size() >= DEPTH) m_ovf = 1;
      else exp_q.push_back('{first: m_first, ack: ack, data: data});
      m_first = 0;
    end
  endtask

  task automatic send_bit(input logic b);
    sda = b; cyc(half);
    scl = 1; cyc(half);
    scl = 0;
  endtask

  task automatic stray(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
    m_bits += n;
  endtask

  // Sends 8 data bits then the ack bit; pop_at_push pops the head in the same
  // cycle that the new record is pushed.
  task automatic send_byte(input logic [7:0] data, input logic ack, input bit pop_at_push = 0);
    for (int i = 7; i >= 0; i--) begin
      send_bit(data[i]);
      cyc(0);
    end
    sda = ack; cyc(half);
    scl = 1;
    if (!pop_at_push) begin
      model_push(data, ack);
      cyc(half);
    end else begin
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("pap_head", head_rec(), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      model_push(data, ack);
      rec_ready = 1;
      @(posedge clk); #1;
      rec_ready = 0;
      cyc(half - 7);
    end
    scl = 0; cyc(half);
  endtask

  task automatic start_cond();
    sda = 1; cyc(half);
    scl = 1; cyc(half);
    sda = 0;
    if (m_busy && m_bits + 1 >= 2) e_ferr++;
    if (en) begin
      e_start++; m_busy = 1; m_first = 1; m_bits = 0;
    end
    cyc(half);
    scl = 0; cyc(half);
  endtask

  task automatic stop_cond();
    sda = 0; cyc(half);
    scl = 1; cyc(half);
    sda = 1;
    if (m_busy) begin
      if (m_bits + 1 >= 2) e_ferr++;
      e_stop++; m_busy = 0; m_bits = 0;
    end
    cyc(half);
  endtask

  task automatic drain_check(input string name, input int n);
    rec_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({name, "_valid"}, 32'(rec_valid), 1);
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL %s: DUT record %0h with nothing expected", name, head_rec());
      end else begin
        e = exp_q.pop_front();
        check({name, "_rec"}, head_rec(), 32'(e));
      end
      @(posedge clk); #1; rec_ready = 1;
      @(posedge clk); #1; rec_ready = 0;
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{restart: 0, data: 8'h91, ack: 1, exp_rec: 10'h391};
    vecs[1] = '{restart: 1, data: 8'h5A, ack: 0, exp_rec: 10'h25A};
    vecs[2] = '{restart: 0, data: 8'h3C, ack: 0, exp_rec: 10'h03C};
    vecs[3] = '{restart: 0, data: 8'hFF, ack: 1, exp_rec: 10'h1FF};
    vecs[4] = '{restart: 1, data: 8'h00, ack: 1, exp_rec: 10'h300};
    vecs[5] = '{restart: 0, data: 8'h81, ack: 0, exp_rec: 10'h081};

    rst = 1; en = 1; scl = 1; sda = 1; rec_ready = 0;
    cyc(3);
    @(negedge clk);
    check("reset_outs", 32'({rec_valid, rec_data, rec_ack, rec_first, bus_busy,
                             start_pulse, stop_pulse, frame_err, overflow}), 0);
    @(posedge clk); #1;
    rst = 0;
    cyc(10);

    // Write 0xA4 + ACK with exact START/STOP pulse timing.
    sda = 0; e_start++; m_busy = 1; m_first = 1; m_bits = 0;
    repeat (6) @(posedge clk);
    @(negedge clk); check("start_early", 32'(start_pulse), 0); check("busy_early", 32'(bus_busy), 0);
    @(negedge clk); check("start_l", 32'(start_pulse), 1);     check("busy_on", 32'(bus_busy), 1);
    @(negedge clk); check("start_width", 32'(start_pulse), 0);
    @(posedge clk); #1;
    scl = 0; cyc(half);
    send_byte(8'hA4, 1'b0);
    sda = 0; cyc(half);
    scl = 1; cyc(half);
    sda = 1; e_stop++; m_busy = 0;
    repeat (6) @(posedge clk);
    @(negedge clk); check("stop_early", 32'(stop_pulse), 0); check("busy_hold", 32'(bus_busy), 1);
    @(negedge clk); check("stop_l", 32'(stop_pulse), 1);     check("busy_off", 32'(bus_busy), 0);
    @(negedge clk); check("stop_width", 32'(stop_pulse), 0);
    @(posedge clk); #1;
    cyc(half);
    check("a4_head", head_rec(), 32'h2A4);
    drain_check("a4", 1);
    check_counts("t1");

    // Table-driven bytes with repeated STARTs, head checked against table constants.
    start_cond();
    foreach (vecs[i]) begin
      if (vecs[i].restart) start_cond();
      send_byte(vecs[i].data, vecs[i].ack);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(rec_valid), 1);
      check($sformatf("vec%0d_rec", i), head_rec(), 32'(vecs[i].exp_rec));
      @(posedge clk); #1; rec_ready = 1;
      @(posedge clk); #1; rec_ready = 0;
      void'(exp_q.pop_front());
    end
    stop_cond();
    check("vec_empty", 32'(rec_valid), 0);
    check_counts("vec");

    // Overflow: six bytes with no consumer.
    start_cond();
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(8'h10 + i), 1'(i));
      @(negedge clk);
      check($sformatf("ovf_byte%0d", i), 32'(overflow), 32'(m_ovf));
      @(posedge clk); #1;
    end
    stop_cond();
    drain_check("ovf_drain", DEPTH);
    check("ovf_empty", 32'(rec_valid), 0);

    // Push together with pop while full: no overflow.
    en = 0; m_busy = 0; m_first = 0; m_ovf = 0; cyc(2); en = 1; cyc(2);
    check("ovf_cleared", 32'(overflow), 0);
    start_cond();
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'hC0 + i), 1'b0);
    send_byte(8'hE7, 1'b1, 1);
    stop_cond();
    @(negedge clk); check("pap_no_ovf", 32'(overflow), 0);
    drain_check("pap_drain", DEPTH);
    check_counts("fifo");

    // Short glitches on an idle bus, then a START with stray bits before STOP.
    scl = 0; cyc(3); scl = 1; cyc(20);
    sda = 0; cyc(3); sda = 1; cyc(20);
    check_counts("glitch");
    check("glitch_busy", 32'(bus_busy), 0);
    start_cond();
    stray(4);
    stop_cond();
    check_counts("stray");
    check("stray_norec", 32'(rec_valid), 0);

    // Reset mid-byte, then a clean transfer.
    start_cond();
    send_byte(8'h66, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1; cyc(2);
    @(negedge clk);
    check("midrst_outs", 32'({rec_valid, rec_data, rec_ack, rec_first, bus_busy,
                              start_pulse, stop_pulse, frame_err, overflow}), 0);
    @(posedge clk); #1;
    rst = 0; exp_q.delete(); m_busy = 0; m_first = 0; m_bits = 0; m_ovf = 0;
    scl = 1; cyc(20);
    start_cond();
    send_byte(8'hC3, 1'b1);
    stop_cond();
    drain_check("after_rst", 1);
    check_counts("rst");

    // Enable dropped during a byte and raised mid-transfer.
    start_cond();
    send_byte(8'h4D, 1'b0);
    send_byte(8'hB2, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    en = 0; m_busy = 0; m_first = 0;
    cyc(2);
    drain_check("en_low_drain", 1);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_byte(8'h33, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    en = 1;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_byte(8'h99, 1'b0);
    stop_cond();
    check_counts("en");
    drain_check("en_rest", 1);
    check("en_empty", 32'(rec_valid), 0);
    start_cond();
    send_byte(8'h5E, 1'b0);
    stop_cond();
    drain_check("en_restart", 1);

    // Randomized transactions with a randomly stalling consumer.
    done = 0;
    fork
      begin
        for (int t = 0; t < 15; t++) begin
          int nb;
          half = $urandom_range(6, 10);
          start_cond();
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) begin
            if (b > 0 && $urandom_range(0, 3) == 0) start_cond();
            send_byte(8'($urandom), 1'($urandom));
          end
          if ($urandom_range(0, 4) == 0) stray($urandom_range(1, 7));
          stop_cond();
          cyc($urandom_range(2, 30));
        end
        done = 1;
      end
      begin
        int guard = 0;
        rec_t e;
        while ((!done || rec_valid === 1'b1) && guard < 60000) begin
          @(negedge clk);
          if (rec_valid === 1'b1 && rec_ready) begin
            if (exp_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL rand_rec: DUT record %0h with nothing expected", head_rec());
            end else begin
              e = exp_q.pop_front();
              check("rand_rec", head_rec(), 32'(e));
            end
          end
          @(posedge clk); #1;
          rec_ready = done ? 1'b1 : 1'($urandom_range(0, 1));
          guard++;
        end
        if (guard >= 60000) begin
          n_tests++; n_fail++;
          $display("FAIL rand_drain: consumer did not finish, valid=%0b", rec_valid);
        end
      end
    join
    rec_ready = 0;
    check("rand_left", exp_q.size(), 0);
    check("rand_ovf", 32'(overflow), 0);
    check_counts("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
